// File: rtl/div_result_bcd_pkg.sv
// Shared defaults and FSM state type for the divider result BCD converter.
package Global;

    localparam int unsigned DW = 8;
    localparam int unsigned ND = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/div_result_bcd_add3.sv
// Double-dabble digit correction: adds 3 to a BCD digit of 5 or more.
module bcd_add3 (
    input  logic [3:0] din,
    output logic [3:0] dout_c
);

    assign dout_c = (din >= 4'd5) ? (din + 4'd3) : din;

endmodule

// File: rtl/div_result_bcd.sv
// Converts divider quotient and remainder to packed BCD with a fixed-latency shift-add-3.
// Optional leading-zero blank masks when DIV_RESULT_BCD_BLANK_EN is defined.
module div_result_bcd #(
    parameter int unsigned DW = Global::DW,
    parameter int unsigned ND = Global::ND
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [DW-1:0]   Cosiente,
    input  logic [DW-1:0]   Residuo,
    output logic            busy,
    output logic            valid,
    output logic [4*ND-1:0] q_bcd,
    output logic [4*ND-1:0] r_bcd
`ifdef DIV_RESULT_BCD_BLANK_EN
    ,
    output logic [ND-1:0]   q_blank,
    output logic [ND-1:0]   r_blank
`endif
);

    import Global::*;

    localparam int unsigned CW = (DW > 1) ? $clog2(DW) : 1;
    localparam int unsigned BW = 4 * ND;
    localparam int unsigned VW = BW + DW;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   q_bin_q, q_bin_d, r_bin_q, r_bin_d;
    logic [BW-1:0]   q_work_q, q_work_d, r_work_q, r_work_d;
    logic [BW-1:0]   q_bcd_q, q_bcd_d, r_bcd_q, r_bcd_d;
    logic            busy_q, busy_d, valid_q, valid_d;
    logic [BW-1:0]   q_corr_c, r_corr_c;
    logic [VW-1:0]   q_vec_c, r_vec_c;

    // Per-digit correction of both working BCD registers.
    for (genvar g = 0; g < ND; g++) begin : g_add3
        bcd_add3 u_q_add3 (.din(q_work_q[4*g +: 4]), .dout_c(q_corr_c[4*g +: 4]));
        bcd_add3 u_r_add3 (.din(r_work_q[4*g +: 4]), .dout_c(r_corr_c[4*g +: 4]));
    end

    assign q_vec_c = {q_corr_c, q_bin_q} << 1;
    assign r_vec_c = {r_corr_c, r_bin_q} << 1;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        q_bin_d  = q_bin_q;
        r_bin_d  = r_bin_q;
        q_work_d = q_work_q;
        r_work_d = r_work_q;
        q_bcd_d  = q_bcd_q;
        r_bcd_d  = r_bcd_q;
        valid_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    q_bin_d  = Cosiente;
                    r_bin_d  = Residuo;
                    q_work_d = '0;
                    r_work_d = '0;
                    cnt_d    = '0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                q_work_d = q_vec_c[VW-1:DW];
                q_bin_d  = q_vec_c[DW-1:0];
                r_work_d = r_vec_c[VW-1:DW];
                r_bin_d  = r_vec_c[DW-1:0];
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(DW - 1)) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                q_bcd_d = q_work_q;
                r_bcd_d = r_work_q;
                valid_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            q_bin_q  <= '0;
            r_bin_q  <= '0;
            q_work_q <= '0;
            r_work_q <= '0;
            q_bcd_q  <= '0;
            r_bcd_q  <= '0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            q_bin_q  <= q_bin_d;
            r_bin_q  <= r_bin_d;
            q_work_q <= q_work_d;
            r_work_q <= r_work_d;
            q_bcd_q  <= q_bcd_d;
            r_bcd_q  <= r_bcd_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
        end
    end

    assign busy  = busy_q;
    assign valid = valid_q;
    assign q_bcd = q_bcd_q;
    assign r_bcd = r_bcd_q;

`ifdef DIV_RESULT_BCD_BLANK_EN
    logic [ND-1:0] q_blank_q, q_blank_d, r_blank_q, r_blank_d;

    // Digit i blanks when it and every higher digit are zero; digit 0 always shows.
    function automatic logic [ND-1:0] blank_mask(input logic [BW-1:0] bcd);
        logic [ND-1:0] m;
        logic          zero_above;
        m          = '0;
        zero_above = 1'b1;
        for (int i = int'(ND) - 1; i > 0; i--) begin
            zero_above = zero_above & (bcd[4*i +: 4] == 4'd0);
            m[i]       = zero_above;
        end
        return m;
    endfunction

    always_comb begin
        q_blank_d = q_blank_q;
        r_blank_d = r_blank_q;
        if (state_q == DONE) begin
            q_blank_d = blank_mask(q_work_q);
            r_blank_d = blank_mask(r_work_q);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_blank_q <= '0;
            r_blank_q <= '0;
        end else begin
            q_blank_q <= q_blank_d;
            r_blank_q <= r_blank_d;
        end
    end

    assign q_blank = q_blank_q;
    assign r_blank = r_blank_q;
`endif

endmodule

// File: tb/tb_div_result_bcd.sv
// Directed self-checking bench for div_result_bcd (DW=8, ND=3).
module tb_div_result_bcd;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  Cosiente;
    logic [7:0]  Residuo;
    logic        busy;
    logic        valid;
    logic [11:0] q_bcd;
    logic [11:0] r_bcd;
`ifdef DIV_RESULT_BCD_BLANK_EN
    logic [2:0]  q_blank;
    logic [2:0]  r_blank;
`endif

    int          total;
    int          bad;
    logic [11:0] last_q;
    logic [11:0] last_r;

    div_result_bcd #(.DW(8), .ND(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .Cosiente (Cosiente),
        .Residuo  (Residuo),
        .busy     (busy),
        .valid    (valid),
        .q_bcd    (q_bcd),
        .r_bcd    (r_bcd)
`ifdef DIV_RESULT_BCD_BLANK_EN
        ,
        .q_blank  (q_blank),
        .r_blank  (r_blank)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Called at posedge+1 with the FSM idle; returns at posedge+1 one cycle after valid.
    task automatic convert(input logic [7:0] a, input logic [7:0] b,
                           input logic [11:0] eq, input logic [11:0] er);
        int n;
        int busy_n;
        bit seen;
        Cosiente = a;
        Residuo  = b;
        start    = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        busy_n = busy ? 1 : 0;
        n      = 0;
        seen   = 1'b0;
        while (!seen && n < 20) begin
            @(posedge clk); #1;
            n++;
            if (n == 4) begin
                chk("hold_q", 32'(q_bcd), 32'(last_q));
                chk("hold_r", 32'(r_bcd), 32'(last_r));
            end
            if (busy) busy_n++;
            if (valid) seen = 1'b1;
        end
        chk("latency", 32'(n), 32'd9);
        chk("busy_cycles", 32'(busy_n), 32'd9);
        chk("q_bcd", 32'(q_bcd), 32'(eq));
        chk("r_bcd", 32'(r_bcd), 32'(er));
        @(posedge clk); #1;
        chk("valid_one_cycle", 32'(valid), 32'd0);
        chk("busy_after", 32'(busy), 32'd0);
        last_q = eq;
        last_r = er;
    endtask

    initial begin
        int vc;
        int vk;
        int first_v;
        int second_v;
        total    = 0;
        bad      = 0;
        last_q   = 12'h000;
        last_r   = 12'h000;
        rst      = 1'b0;
        start    = 1'b0;
        Cosiente = 8'd0;
        Residuo  = 8'd0;

        #3;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_q", 32'(q_bcd), 32'd0);
        chk("rst_r", 32'(r_bcd), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        convert(8'd255, 8'd0, 12'h255, 12'h000);
        convert(8'd100, 8'd7, 12'h100, 12'h007);
        convert(8'd0, 8'd255, 12'h000, 12'h255);

        // A second start three cycles into a conversion must be ignored.
        Cosiente = 8'd200;
        Residuo  = 8'd13;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        vc = 0;
        vk = 0;
        for (int k = 1; k <= 20; k++) begin
            if (k == 3) begin
                Cosiente = 8'd50;
                Residuo  = 8'd1;
                start    = 1'b1;
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (valid) begin
                vc++;
                vk = k;
                chk("ignore_q", 32'(q_bcd), 32'h200);
                chk("ignore_r", 32'(r_bcd), 32'h013);
            end
        end
        chk("ignore_valid_count", 32'(vc), 32'd1);
        chk("ignore_latency", 32'(vk), 32'd9);
        last_q = 12'h200;
        last_r = 12'h013;

        // Reset in the fourth SHIFT cycle aborts the conversion.
        Cosiente = 8'd99;
        Residuo  = 8'd9;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_valid", 32'(valid), 32'd0);
        chk("abort_q", 32'(q_bcd), 32'd0);
        chk("abort_r", 32'(r_bcd), 32'd0);
`ifdef DIV_RESULT_BCD_BLANK_EN
        chk("abort_qblank", 32'(q_blank), 32'd0);
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        vc = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (valid || busy) vc++;
        end
        chk("no_restart_after_abort", 32'(vc), 32'd0);
        last_q = 12'h000;
        last_r = 12'h000;
        convert(8'd42, 8'd5, 12'h042, 12'h005);

        // Start held high: accepts every 10 cycles, valid lands in an idle cycle.
        Cosiente = 8'd123;
        Residuo  = 8'd45;
        start    = 1'b1;
        vc       = 0;
        first_v  = 0;
        second_v = 0;
        for (int k = 1; k <= 32; k++) begin
            @(posedge clk); #1;
            if (k == 11) chk("b2b_reaccept", 32'(busy), 32'd1);
            if (valid) begin
                vc++;
                if (vc == 1) first_v = k;
                if (vc == 2) second_v = k;
                chk("b2b_idle_at_valid", 32'(busy), 32'd0);
                chk("b2b_q", 32'(q_bcd), 32'h123);
                chk("b2b_r", 32'(r_bcd), 32'h045);
            end
        end
        start = 1'b0;
        chk("b2b_first", 32'(first_v), 32'd10);
        chk("b2b_period", 32'(second_v - first_v), 32'd10);
        chk("b2b_count", 32'(vc), 32'd3);
        repeat (12) begin
            @(posedge clk); #1;
        end
        last_q = 12'h123;
        last_r = 12'h045;

`ifdef DIV_RESULT_BCD_BLANK_EN
        convert(8'd7, 8'd0, 12'h007, 12'h000);
        chk("qblank_7", 32'(q_blank), 32'b110);
        chk("rblank_0", 32'(r_blank), 32'b110);
        convert(8'd120, 8'd0, 12'h120, 12'h000);
        chk("qblank_120", 32'(q_blank), 32'b000);
        chk("rblank_0b", 32'(r_blank), 32'b110);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
